// File: rtl/conv_mac_engine.sv
// conv_mac_engine: streaming multiply-accumulate over one convolution window.
// Each accepted beat adds the sum of NUM_CH pixel*weight products into a wide
// accumulator. After KERNEL_SIZE*KERNEL_SIZE beats the sum is shifted,
// saturated to DATA_WIDTH and held on o_result until downstream accepts it.
module conv_mac_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_CH      = 2,
    parameter int SHIFT       = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_pix,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_kern,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_result,
    output logic                         o_sat,
    output logic                         o_done,
    output logic                         o_busy
);

    localparam int BEATS = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_CH * BEATS) + 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    sat_q, sat_d;
    logic                    done_q, done_d;

    logic [ACC_W-1:0]        beat_sum;
    logic [ACC_W-1:0]        acc_sum;
    logic [ACC_W-1:0]        shifted;
    logic                    overflow;

    // Full-precision sum of the per-channel products for the current beat.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so the loop accumulates in order.
        beat_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            beat_sum = beat_sum
                     + ACC_W'(i_pix[c*DATA_WIDTH +: DATA_WIDTH])
                     * ACC_W'(i_kern[c*DATA_WIDTH +: DATA_WIDTH]);
        end
        acc_sum  = acc_q + beat_sum;
        shifted  = acc_sum >> SHIFT;
        overflow = |shifted[ACC_W-1:DATA_WIDTH];
    end

    // Next-state logic: abort first, then the IDLE -> ACCUM -> OUT -> IDLE walk.
    always_comb begin
        // NOTE: every _d gets a default hold value first, so no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        result_d = result_q;
        sat_d    = sat_q;
        done_d   = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_ACCUM: begin
                    if (i_valid) begin
                        if (cnt_q == LAST_BEAT) begin
                            // Final beat: capture the saturated result from the sum including it.
                            state_d  = ST_OUT;
                            acc_d    = acc_sum;
                            cnt_d    = '0;
                            valid_d  = 1'b1;
                            result_d = overflow ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
                            sat_d    = overflow;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: registers take non-blocking '<=' so all flops update from pre-edge values.
        if (i_rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
        end
    end

    assign o_ready  = (state_q == ST_ACCUM);
    assign o_busy   = (state_q != ST_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_sat    = sat_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine. Two instances share all inputs: one with
// default parameters, one with SHIFT=12 to exercise the post-shift saturation path.
module tb_conv_mac_engine;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic          i_valid;
    logic          i_ready;
    logic [2*DW-1:0] i_pix;
    logic [2*DW-1:0] i_kern;

    logic          o_ready,  o_valid,  o_sat,  o_done,  o_busy;
    logic [DW-1:0] o_result;
    logic          s_ready,  s_valid,  s_sat,  s_done,  s_busy;
    logic [DW-1:0] s_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_mac_engine dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_pix    (i_pix),
        .i_kern   (i_kern),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_sat    (o_sat),
        .o_done   (o_done),
        .o_busy   (o_busy)
    );

    conv_mac_engine #(.SHIFT(12)) dut_shift (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_valid  (i_valid),
        .o_ready  (s_ready),
        .i_pix    (i_pix),
        .i_kern   (i_kern),
        .o_valid  (s_valid),
        .i_ready  (i_ready),
        .o_result (s_result),
        .o_sat    (s_sat),
        .o_done   (s_done),
        .o_busy   (s_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_beats(input int n);
        i_valid = 1'b1;
        repeat (n) tick();
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_pix   = '0;
        i_kern  = '0;

        // Reset state
        tick();
        tick();
        check("rst_valid",  o_valid,  0);
        check("rst_result", o_result, 0);
        check("rst_sat",    o_sat,    0);
        check("rst_done",   o_done,   0);
        check("rst_busy",   o_busy,   0);
        check("rst_ready",  o_ready,  0);
        i_rst = 1'b0;
        tick();
        check("idle_ready", o_ready, 0);

        // Back-to-back window of ones: 9 * (1*1 + 1*1) = 18
        i_ready = 1'b1;
        i_pix   = {8'd1, 8'd1};
        i_kern  = {8'd1, 8'd1};
        start_window();
        check("accum_busy",  o_busy,  1);
        check("accum_ready", o_ready, 1);
        i_valid = 1'b1;
        for (int b = 0; b < 9; b++) begin
            tick();
            if (b == 7) check("ones_valid_before_last", o_valid, 0);
        end
        i_valid = 1'b0;
        check("ones_valid",     o_valid,  1);
        check("ones_result",    o_result, 18);
        check("ones_sat",       o_sat,    0);
        check("ones_done_early", o_done,  0);
        check("out_ready",      o_ready,  0);
        tick();
        check("ones_done",       o_done,  1);
        check("ones_valid_drop", o_valid, 0);
        check("ones_idle",       o_busy,  0);
        tick();
        check("ones_done_single", o_done, 0);

        // Full-scale window: 9 * 2 * 65025 = 1170450 saturates both instances (>>12 gives 285)
        i_pix  = {8'd255, 8'd255};
        i_kern = {8'd255, 8'd255};
        start_window();
        run_beats(9);
        check("full_result",       o_result, 255);
        check("full_sat",          o_sat,    1);
        check("full_shift_result", s_result, 255);
        check("full_shift_sat",    s_sat,    1);
        tick();

        // 9 * (255*255 + 255*200) = 1044225; >>12 = 254 fits, unshifted saturates
        i_kern = {8'd200, 8'd255};
        start_window();
        run_beats(9);
        check("mix_result",       o_result, 255);
        check("mix_sat",          o_sat,    1);
        check("mix_shift_result", s_result, 254);
        check("mix_shift_sat",    s_sat,    0);
        tick();

        // Bubbles every other cycle: 9 * (2*4 + 3*5) = 207
        i_pix  = {8'd3, 8'd2};
        i_kern = {8'd5, 8'd4};
        start_window();
        for (int i = 0; i < 17; i++) begin
            i_valid = (i % 2 == 0);
            tick();
            if (i == 15) check("bubble_valid_after_8", o_valid, 0);
        end
        i_valid = 1'b0;
        check("bubble_valid",  o_valid,  1);
        check("bubble_result", o_result, 207);
        tick();

        // Back-pressure: hold OUT for 5 cycles with i_start asserted throughout
        i_ready = 1'b0;
        i_pix   = {8'd1, 8'd1};
        i_kern  = {8'd1, 8'd1};
        start_window();
        run_beats(9);
        i_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid",  o_valid,  1);
            check("hold_result", o_result, 18);
            check("hold_done",   o_done,   0);
            tick();
        end
        check("hold_valid_end", o_valid, 1);
        i_ready = 1'b1;
        tick();
        check("hold_done_on_accept", o_done, 1);
        check("hold_start_ignored",  o_busy, 0);
        i_start = 1'b0;
        tick();
        check("hold_done_single", o_done, 0);
        check("hold_still_idle",  o_busy, 0);

        // Abort after beat 4, with a valid beat coincident to prove priority
        start_window();
        run_beats(4);
        i_valid = 1'b1;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        check("abort_busy",  o_busy,  0);
        check("abort_valid", o_valid, 0);
        check("abort_done",  o_done,  0);
        check("abort_ready", o_ready, 0);
        tick();
        check("abort_valid_later", o_valid, 0);
        check("abort_done_later",  o_done,  0);
        start_window();
        run_beats(9);
        check("post_abort_result", o_result, 18);
        tick();
        check("post_abort_done", o_done, 1);

        // Reset mid-window after beat 6, then a fresh window: 9 * (1*3) = 27
        i_pix  = {8'd0, 8'd1};
        i_kern = {8'd0, 8'd3};
        start_window();
        run_beats(6);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_busy",   o_busy,   0);
        check("midrst_ready",  o_ready,  0);
        check("midrst_valid",  o_valid,  0);
        check("midrst_result", o_result, 0);
        check("midrst_sat",    o_sat,    0);
        check("midrst_done",   o_done,   0);
        tick();
        i_rst = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("postrst_wait_busy",  o_busy,  0);
            check("postrst_wait_valid", o_valid, 0);
        end
        i_valid = 1'b0;
        start_window();
        run_beats(9);
        check("postrst_result", o_result, 27);
        check("postrst_sat",    o_sat,    0);
        tick();
        check("postrst_done", o_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
